// File: rtl/bcd_row_formatter_if.sv
// rtl/bcd_row_formatter_if.sv - converter handshake and LCD row bundle for bcd_row_formatter
interface bcd_row_formatter_if #(
   parameter int DIGITS = 7
);
   logic                  conv_enable;
   logic                  conv_valid;
   logic [4*DIGITS-1:0]   conv_bcd;
   logic [127:0]          row_text;
   logic                  row_valid;
   logic                  timeout;

   modport master (
      output conv_enable,
      input  conv_valid,
      input  conv_bcd,
      output row_text,
      output row_valid,
      output timeout
   );

   modport slave (
      input  conv_enable,
      output conv_valid,
      output conv_bcd,
      input  row_text,
      input  row_valid,
      input  timeout
   );
endinterface

// File: rtl/bcd_row_formatter.sv
// rtl/bcd_row_formatter.sv - requests a BCD conversion and formats it into a 16-char ASCII row
module bcd_row_formatter #(
   parameter int DIGITS        = 7,
   parameter int VALID_MASK    = 3,
   parameter int WAIT_LIMIT    = 63,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   bcd_row_formatter_if.master   bus
);
   localparam int WW = $clog2(WAIT_LIMIT + 1);
   localparam int IW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {IDLE, REQ, FMT, DONE} state_t;

   state_t                state;
   logic [WW-1:0]         wait_cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   cap;
   logic [8*DIGITS-1:0]   shadow;
   logic                  seen_nz;
   logic                  err;
   logic                  en_q;
   logic [127:0]          row_q;
   logic                  row_valid_q;
   logic                  timeout_q;

   logic [3:0]            digit;
   logic                  last;
   logic [7:0]            ch;
   logic [127:0]          row_next;

   // Reset gates the enable combinationally so the converter sees it fall at once.
   assign bus.conv_enable = en_q & ~reset;
   assign bus.row_text    = row_q;
   assign bus.row_valid   = row_valid_q;
   assign bus.timeout     = timeout_q;

   always_comb begin
      digit = cap[4*DIGITS-1 -: 4];
      last  = (idx == IW'(DIGITS - 1));
      ch    = {4'h3, digit};
      if (digit > 4'd9)
         ch = 8'h3F;
      else if (digit == 4'd0 && BLANK_LEADING != 0 && !seen_nz && !last)
         ch = 8'h20;
   end

   always_comb begin
      row_next          = {16{8'h20}};
      row_next[127 -: 8] = 8'h54;
      row_next[119 -: 8] = 8'h3A;
      for (int i = 0; i < DIGITS; i++)
         row_next[127-8*(3+i) -: 8] = err ? 8'h2D : shadow[8*(DIGITS-1-i) +: 8];
      row_next[127-8*(4+DIGITS) -: 8] = 8'h6D;
      row_next[127-8*(5+DIGITS) -: 8] = 8'h73;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         en_q        <= 1'b0;
         row_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         row_q       <= {16{8'h20}};
         wait_cnt    <= '0;
         idx         <= '0;
         cap         <= '0;
         shadow      <= '0;
         seen_nz     <= 1'b0;
         err         <= 1'b0;
      end else begin
         row_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= REQ;
                  busy     <= 1'b1;
                  en_q     <= 1'b1;
                  wait_cnt <= '0;
                  err      <= 1'b0;
               end
            end
            REQ: begin
               // Early valids are masked: they may be left over from the previous result.
               if (bus.conv_valid && wait_cnt >= WW'(VALID_MASK)) begin
                  cap     <= bus.conv_bcd;
                  en_q    <= 1'b0;
                  idx     <= '0;
                  seen_nz <= 1'b0;
                  state   <= FMT;
               end else if (wait_cnt == WW'(WAIT_LIMIT - 1)) begin
                  en_q  <= 1'b0;
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            FMT: begin
               shadow[8*(DIGITS-1-int'(idx)) +: 8] <= ch;
               cap <= cap << 4;
               if (digit != 4'd0)
                  seen_nz <= 1'b1;
               idx <= idx + 1'b1;
               if (last)
                  state <= DONE;
            end
            DONE: begin
               row_q       <= row_next;
               row_valid_q <= 1'b1;
               timeout_q   <= err;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_row_formatter.sv
// tb/tb_bcd_row_formatter.sv - randomized scoreboard bench for bcd_row_formatter
module tb_bcd_row_formatter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        conv_valid = 1'b0;
   logic [27:0] conv_bcd = '0;
   logic        busy0, busy1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      logic [127:0] row;
      bit           to;
      int           cyc;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   bcd_row_formatter_if #(.DIGITS(7)) bus0();
   bcd_row_formatter_if #(.DIGITS(7)) bus1();

   assign bus0.conv_valid = conv_valid;
   assign bus0.conv_bcd   = conv_bcd;
   assign bus1.conv_valid = conv_valid;
   assign bus1.conv_bcd   = conv_bcd;

   bcd_row_formatter #(.DIGITS(7), .VALID_MASK(3), .WAIT_LIMIT(63), .BLANK_LEADING(1)) u0 (
      .clk(clk), .reset(reset), .start(start), .busy(busy0), .bus(bus0.master));
   bcd_row_formatter #(.DIGITS(7), .VALID_MASK(3), .WAIT_LIMIT(63), .BLANK_LEADING(0)) u1 (
      .clk(clk), .reset(reset), .start(start), .busy(busy1), .bus(bus1.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   localparam logic [127:0] SPACES = {16{8'h20}};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: BCD is read as a decimal number and printed with printf-style padding.
   function automatic logic [127:0] exp_row(input logic [27:0] bcd, input bit blank, input bit err);
      string       s;
      longint      v = 0;
      bit          bad = 0;
      bit          lead;
      int          d;
      logic [127:0] r;
      for (int i = 6; i >= 0; i--) begin
         d = int'((bcd >> (4*i)) & 28'hF);
         if (d > 9) bad = 1;
         v = v * 10 + d;
      end
      if (err)
         s = "T: ------- ms   ";
      else if (!bad)
         s = blank ? $sformatf("T: %7d ms   ", v) : $sformatf("T: %07d ms   ", v);
      else begin
         s = "T: ";
         lead = blank;
         for (int i = 6; i >= 0; i--) begin
            d = int'((bcd >> (4*i)) & 28'hF);
            if (d > 9) begin
               s = {s, "?"};
               lead = 0;
            end else if (d == 0 && lead && i != 0)
               s = {s, " "};
            else begin
               s = {s, $sformatf("%0d", d)};
               lead = 0;
            end
         end
         s = {s, " ms   "};
      end
      for (int k = 0; k < 16; k++)
         r[127-8*k -: 8] = s[k];
      return r;
   endfunction

   function automatic logic [27:0] to_bcd(input int unsigned v);
      logic [27:0] b = '0;
      for (int i = 0; i < 7; i++) begin
         b[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return b;
   endfunction

   // Monitors: pop one expected row per row_valid pulse.
   always @(negedge clk) begin
      exp_t e;
      if (bus0.row_valid === 1'b1) begin
         if (q0.size() == 0) chk("unexpected_row0", 1, 0);
         else begin
            e = q0.pop_front();
            chk("row0", bus0.row_text, e.row);
            chk("timeout0", 128'(bus0.timeout), 128'(e.to));
            chk("latency0", 128'(cyc), 128'(e.cyc));
         end
      end else if (bus0.timeout === 1'b1)
         chk("stray_timeout0", 1, 0);
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus1.row_valid === 1'b1) begin
         if (q1.size() == 0) chk("unexpected_row1", 1, 0);
         else begin
            e = q1.pop_front();
            chk("row1", bus1.row_text, e.row);
            chk("timeout1", 128'(bus1.timeout), 128'(e.to));
         end
      end
   end

   task automatic push_exp(input logic [27:0] bcd, input bit to, input int at);
      q0.push_back('{row: exp_row(bcd, 1, to), to: to, cyc: at});
      q1.push_back('{row: exp_row(bcd, 0, to), to: to, cyc: at});
   endtask

   task automatic do_conv(input logic [27:0] bcd, input int valid_at, input bit stale,
                          input bit to, input bit poke_start, input bit rst_mid);
      int w = 0;
      int guard = 0;
      bit done = 0;
      bit capt;
      while (busy0 !== 1'b0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (busy0 !== 1'b0) begin
         chk("idle_wait_bound", 128'(busy0), 0);
         return;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done) begin
         if (stale && w < 3) begin
            conv_valid = 1'b1;
            conv_bcd   = 28'h5555555;
         end else if (!to && w >= valid_at) begin
            conv_valid = 1'b1;
            conv_bcd   = bcd;
         end else begin
            conv_valid = 1'b0;
            conv_bcd   = 28'($urandom);
         end
         #1;
         chk("conv_enable_req", 128'(bus0.conv_enable), 1);
         capt = conv_valid && w >= 3;
         @(posedge clk); #1;
         if (capt) begin
            push_exp(bcd, 0, cyc + 8);
            done = 1;
         end else if (w == 62) begin
            push_exp(bcd, 1, cyc + 1);
            done = 1;
         end
         w++;
      end
      conv_valid = 1'b0;
      conv_bcd   = 28'($urandom);
      chk("conv_enable_off", 128'(bus0.conv_enable), 0);
      if (poke_start) begin
         start = 1'b1;
         conv_bcd = 28'($urandom);
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (rst_mid) begin
         @(posedge clk); #1;
         reset = 1'b1;
         @(posedge clk); #1;
         chk("rst_busy", 128'(busy0), 0);
         chk("rst_conv_enable", 128'(bus0.conv_enable), 0);
         chk("rst_row_text", bus0.row_text, SPACES);
         chk("rst_row_valid", 128'(bus0.row_valid), 0);
         reset = 1'b0;
         void'(q0.pop_back());
         void'(q1.pop_back());
         repeat (12) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [27:0] b;
      int          n;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 128'(busy0), 0);
      chk("reset_conv_enable", 128'(bus0.conv_enable), 0);
      chk("reset_row_valid", 128'(bus0.row_valid), 0);
      chk("reset_timeout", 128'(bus0.timeout), 0);
      chk("reset_row_text", bus0.row_text, SPACES);
      reset = 1'b0;
      @(posedge clk); #1;

      do_conv(28'h0000123, 5, 0, 0, 0, 0);
      do_conv(28'h0000000, 3, 0, 0, 0, 0);
      do_conv(28'h9999999, 4, 0, 0, 0, 0);
      do_conv(28'h0000042, 5, 1, 0, 0, 0);
      do_conv(28'h0000777, 0, 0, 0, 0, 0);
      do_conv(28'h0000000, 0, 0, 1, 0, 0);
      do_conv(28'h00A0012, 6, 0, 0, 1, 0);
      do_conv(28'h1234567, 4, 0, 0, 0, 0);
      for (int t = 0; t < 12; t++) begin
         n = int'($urandom_range(0, 7));
         b = to_bcd($urandom_range(0, (n == 7) ? 9999999 : (10 ** n)));
         if ($urandom_range(0, 3) == 0)
            b[4*$urandom_range(0, 6) +: 4] = 4'($urandom_range(10, 15));
         do_conv(b, int'($urandom_range(0, 10)), bit'($urandom_range(0, 1)), 0,
                 bit'($urandom_range(0, 1)), 0);
      end
      do_conv(28'h0000321, 5, 0, 0, 0, 1);
      do_conv(28'h0005000, 3, 0, 0, 0, 0);

      for (int g = 0; g < 40 && (q0.size() != 0 || q1.size() != 0); g++)
         @(posedge clk);
      #1;
      chk("drain_q0", 128'(q0.size()), 0);
      chk("drain_q1", 128'(q1.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
